// File: rtl/ble_rx_pkg.sv
// rtl/ble_rx_pkg.sv - shared types and constants for the BLE receive path
package ble_rx_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CRC     = 2'd3
   } rx_state_e;

   localparam logic [23:0] CRC_POLY     = 24'h00065B;
   localparam logic [31:0] ADV_AA       = 32'h8E89BED6;
   localparam logic [23:0] ADV_CRC_INIT = 24'h555555;

   // Number of set bits in a 32-bit word, used for the AA Hamming distance.
   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + {5'b0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/ble_packet_deframer_if.sv
// rtl/ble_packet_deframer_if.sv - bit stream in / byte stream out bundle
interface ble_packet_deframer_if;

   logic       bit_valid;
   logic       bit_in;
   logic [7:0] byte_out;
   logic       byte_valid;

   modport master (output bit_valid, output bit_in, input byte_out, input byte_valid);
   modport slave  (input bit_valid, input bit_in, output byte_out, output byte_valid);

endinterface

// File: rtl/ble_crc24.sv
// rtl/ble_crc24.sv - serial 24-bit BLE CRC engine, one bit per enable
module ble_crc24
   import ble_rx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [23:0] init,
   input  logic        en,
   input  logic        din,
   output logic [23:0] crc
);

   logic [23:0] crc_q, crc_d;
   logic        fb;

   // Preset on load, otherwise shift one bit through the LFSR when enabled.
   always_comb begin
      crc_d = crc_q;
      fb    = crc_q[23] ^ din;
      if (load) begin
         crc_d = init;
      end else if (en) begin
         crc_d = {crc_q[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h000000);
      end
   end

   // CRC register.
   always_ff @(posedge clk) begin
      if (rst) crc_q <= '0;
      else     crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/ble_packet_deframer.sv
// rtl/ble_packet_deframer.sv - BLE AA hunt, dewhitening, byte framing and CRC check
module ble_packet_deframer
   import ble_rx_pkg::*;
#(
   parameter int AA_ERR_TOL = 2,
   parameter int MAX_LEN    = 37
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [31:0]           aa,
   input  logic [5:0]            channel,
   input  logic [23:0]           crc_init,
   ble_packet_deframer_if.slave  bus,
   output logic                  aa_found,
   output logic                  pkt_done,
   output logic                  crc_ok,
   output logic                  len_err,
   output logic                  busy
);

   localparam logic [5:0] TOL6     = 6'(AA_ERR_TOL);
   localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

   rx_state_e   state_q, state_d;
   logic [31:0] sr_q, sr_d;
   logic [5:0]  fill_q, fill_d;
   logic [6:0]  lfsr_q, lfsr_d;
   logic [10:0] cnt_q, cnt_d;
   logic [7:0]  byte_q, byte_d;
   logic [7:0]  len_q, len_d;
   logic [23:0] rx_crc_q, rx_crc_d;
   logic [7:0]  byte_out_q, byte_out_d;
   logic        byte_valid_q, byte_valid_d;
   logic        aa_found_q, aa_found_d;
   logic        pkt_done_q, pkt_done_d;
   logic        crc_ok_q, crc_ok_d;
   logic        len_err_q, len_err_d;

   logic [31:0] sr_shift;
   logic [5:0]  fill_inc;
   logic [6:0]  lfsr_step;
   logic [7:0]  byte_next;
   logic        dbit, match, crc_load, crc_en;
   logic [23:0] crc_val;

   ble_crc24 u_crc (
      .clk  (clk),
      .rst  (rst),
      .load (crc_load),
      .init (crc_init),
      .en   (crc_en),
      .din  (dbit),
      .crc  (crc_val)
   );

   // Next-state logic: AA hunt, then header/payload/CRC bit sequencing.
   always_comb begin
      state_d      = state_q;
      sr_d         = sr_q;
      fill_d       = fill_q;
      lfsr_d       = lfsr_q;
      cnt_d        = cnt_q;
      byte_d       = byte_q;
      len_d        = len_q;
      rx_crc_d     = rx_crc_q;
      byte_out_d   = byte_out_q;
      byte_valid_d = 1'b0;
      aa_found_d   = 1'b0;
      pkt_done_d   = 1'b0;
      crc_ok_d     = 1'b0;
      len_err_d    = 1'b0;
      crc_load     = 1'b0;
      crc_en       = 1'b0;

      sr_shift  = {bus.bit_in, sr_q[31:1]};
      fill_inc  = (fill_q == 6'd32) ? fill_q : fill_q + 6'd1;
      dbit      = bus.bit_in ^ lfsr_q[6];
      lfsr_step = {lfsr_q[5:0], lfsr_q[6]} ^ {2'b00, lfsr_q[6], 4'b0000};
      byte_next = {dbit, byte_q[7:1]};
      match     = (fill_inc == 6'd32) && (popcount32(sr_shift ^ aa) <= TOL6);

      if (!en) begin
         state_d = ST_SEARCH;
         fill_d  = '0;
      end else if (bus.bit_valid) begin
         sr_d = sr_shift;
         case (state_q)
            ST_SEARCH: begin
               fill_d = fill_inc;
               if (match) begin
                  aa_found_d = 1'b1;
                  lfsr_d     = {1'b1, channel};
                  crc_load   = 1'b1;
                  cnt_d      = '0;
                  state_d    = ST_HEADER;
               end
            end
            ST_HEADER, ST_PAYLOAD: begin
               lfsr_d = lfsr_step;
               crc_en = 1'b1;
               byte_d = byte_next;
               cnt_d  = cnt_q + 11'd1;
               if (cnt_q[2:0] == 3'd7) begin
                  byte_out_d   = byte_next;
                  byte_valid_d = 1'b1;
               end
               if (state_q == ST_HEADER && cnt_q == 11'd15) begin
                  len_d = byte_next;
                  cnt_d = '0;
                  if (byte_next > MAX_LEN8) begin
                     len_err_d = 1'b1;
                     state_d   = ST_SEARCH;
                     fill_d    = '0;
                  end else if (byte_next == 8'd0) begin
                     state_d = ST_CRC;
                  end else begin
                     state_d = ST_PAYLOAD;
                  end
               end else if (state_q == ST_PAYLOAD && cnt_q == {len_q, 3'b000} - 11'd1) begin
                  cnt_d   = '0;
                  state_d = ST_CRC;
               end
            end
            ST_CRC: begin
               lfsr_d   = lfsr_step;
               rx_crc_d = {rx_crc_q[22:0], dbit};
               cnt_d    = cnt_q + 11'd1;
               if (cnt_q == 11'd23) begin
                  pkt_done_d = 1'b1;
                  crc_ok_d   = (rx_crc_d == crc_val);
                  state_d    = ST_SEARCH;
                  fill_d     = '0;
               end
            end
            default: state_d = ST_SEARCH;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_SEARCH;
         sr_q         <= '0;
         fill_q       <= '0;
         lfsr_q       <= '0;
         cnt_q        <= '0;
         byte_q       <= '0;
         len_q        <= '0;
         rx_crc_q     <= '0;
         byte_out_q   <= '0;
         byte_valid_q <= 1'b0;
         aa_found_q   <= 1'b0;
         pkt_done_q   <= 1'b0;
         crc_ok_q     <= 1'b0;
         len_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sr_q         <= sr_d;
         fill_q       <= fill_d;
         lfsr_q       <= lfsr_d;
         cnt_q        <= cnt_d;
         byte_q       <= byte_d;
         len_q        <= len_d;
         rx_crc_q     <= rx_crc_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         aa_found_q   <= aa_found_d;
         pkt_done_q   <= pkt_done_d;
         crc_ok_q     <= crc_ok_d;
         len_err_q    <= len_err_d;
      end
   end

   assign bus.byte_out   = byte_out_q;
   assign bus.byte_valid = byte_valid_q;
   assign aa_found       = aa_found_q;
   assign pkt_done       = pkt_done_q;
   assign crc_ok         = crc_ok_q;
   assign len_err        = len_err_q;
   assign busy           = (state_q != ST_SEARCH);

endmodule

// File: tb/tb_ble_packet_deframer.sv
// tb/tb_ble_packet_deframer.sv - directed self-checking bench for ble_packet_deframer
module tb_ble_packet_deframer;
   import ble_rx_pkg::*;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [31:0] aa;
   logic [5:0]  channel;
   logic [23:0] crc_init;
   logic        aa_found, pkt_done, crc_ok, len_err, busy;

   ble_packet_deframer_if bus();

   ble_packet_deframer #(.AA_ERR_TOL(2), .MAX_LEN(37)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .aa       (aa),
      .channel  (channel),
      .crc_init (crc_init),
      .bus      (bus),
      .aa_found (aa_found),
      .pkt_done (pkt_done),
      .crc_ok   (crc_ok),
      .len_err  (len_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic       tx[$];
   logic [7:0] pdu[$];
   logic [7:0] rx_bytes[$];
   int         sidx, n_aa, aa_idx, n_byte, n_done, done_idx, n_lenerr, lenerr_idx;
   logic       done_ok;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_log();
      sidx = 0; n_aa = 0; aa_idx = -1; n_byte = 0; n_done = 0; done_idx = -1;
      n_lenerr = 0; lenerr_idx = -1; done_ok = 1'b0;
      rx_bytes.delete();
   endtask

   // One clock: drive at negedge, sample registered outputs just after posedge.
   task automatic tick(input logic v, input logic b);
      @(negedge clk);
      bus.bit_valid = v;
      bus.bit_in    = b;
      @(posedge clk);
      #1;
      if (v) sidx++;
      if (aa_found) begin n_aa++; aa_idx = sidx - 1; end
      if (bus.byte_valid) begin n_byte++; rx_bytes.push_back(bus.byte_out); end
      if (pkt_done) begin n_done++; done_idx = sidx - 1; done_ok = crc_ok; end
      if (len_err) begin n_lenerr++; lenerr_idx = sidx - 1; end
   endtask

   // Transmitter model: preamble, AA, whitened PDU, whitened CRC (MSB first).
   task automatic build(input logic [31:0] aa_tx, input int flip);
      logic [6:0]  lf;
      logic [23:0] c;
      logic        d, w;
      tx.delete();
      for (int i = 0; i < 8; i++) tx.push_back(i % 2 == 1);
      for (int i = 0; i < 32; i++) tx.push_back(aa_tx[i]);
      lf = {1'b1, channel};
      c  = crc_init;
      for (int k = 0; k < pdu.size(); k++) begin
         for (int i = 0; i < 8; i++) begin
            d  = pdu[k][i];
            c  = {c[22:0], 1'b0} ^ ((c[23] ^ d) ? CRC_POLY : 24'h000000);
            w  = d ^ lf[6];
            lf = {lf[5:0], lf[6]} ^ {2'b00, lf[6], 4'b0000};
            if (k * 8 + i == flip) w = ~w;
            tx.push_back(w);
         end
      end
      for (int i = 23; i >= 0; i--) begin
         w  = c[i] ^ lf[6];
         lf = {lf[5:0], lf[6]} ^ {2'b00, lf[6], 4'b0000};
         tx.push_back(w);
      end
   endtask

   task automatic send_range(input int first, input int last, input bit gaps);
      for (int n = first; n <= last; n++) begin
         tick(1'b1, tx[n]);
         if (gaps) tick(1'b0, 1'b0);
      end
   endtask

   task automatic send_all(input bit gaps);
      send_range(0, tx.size() - 1, gaps);
      for (int n = 0; n < 4; n++) tick(1'b0, 1'b0);
   endtask

   task automatic load_adv();
      pdu.delete();
      pdu = '{8'h40, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; aa = ADV_AA; channel = 6'd37; crc_init = ADV_CRC_INIT;
      bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
      clear_log();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", {18'd0, aa_found, pkt_done, crc_ok, len_err, busy,
                           bus.byte_valid, bus.byte_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0; en = 1'b1;

      // 1: clean advertising packet, back-to-back strobes
      load_adv(); build(ADV_AA, -1); clear_log(); send_all(1'b0);
      check("t1_aa_cnt", n_aa, 1);
      check("t1_aa_idx", aa_idx, 39);
      check("t1_byte_cnt", n_byte, 8);
      for (int k = 0; k < 8; k++)
         if (k < rx_bytes.size()) check($sformatf("t1_byte%0d", k), rx_bytes[k], pdu[k]);
      check("t1_done_cnt", n_done, 1);
      check("t1_done_idx", done_idx, 127);
      check("t1_crc_ok", done_ok, 1);
      check("t1_byte_hold", bus.byte_out, 8'h66);
      check("t1_busy", busy, 0);

      // 2: payload bit flipped, strobes with idle gaps
      build(ADV_AA, 20); clear_log(); send_all(1'b1);
      check("t2_byte_cnt", n_byte, 8);
      if (rx_bytes.size() > 2) check("t2_byte2", rx_bytes[2], 8'h01);
      check("t2_done_cnt", n_done, 1);
      check("t2_crc_ok", done_ok, 0);

      // 3: AA with 2 errors matches, with 3 errors does not
      build(ADV_AA ^ 32'h0000_0101, -1); clear_log(); send_all(1'b0);
      check("t3a_aa_cnt", n_aa, 1);
      check("t3a_crc_ok", done_ok, 1);
      build(ADV_AA ^ 32'h0001_0101, -1); clear_log(); send_all(1'b0);
      check("t3b_aa_cnt", n_aa, 0);
      check("t3b_byte_cnt", n_byte, 0);
      check("t3b_done_cnt", n_done, 0);

      // 4: length 0xFF aborts, next packet re-acquired
      pdu.delete(); pdu = '{8'h00, 8'hFF};
      build(ADV_AA, -1); clear_log(); send_all(1'b0);
      check("t4_lenerr_cnt", n_lenerr, 1);
      check("t4_lenerr_idx", lenerr_idx, 55);
      check("t4_busy", busy, 0);
      load_adv(); build(ADV_AA, -1); send_all(1'b0);
      check("t4_aa_cnt", n_aa, 2);
      check("t4_done_cnt", n_done, 1);
      check("t4_crc_ok", done_ok, 1);

      // 5: en dropped mid-payload
      build(ADV_AA, -1); clear_log();
      send_range(0, 69, 1'b0);
      en = 1'b0;
      tick(1'b1, tx[70]);
      check("t5_busy", busy, 0);
      send_range(71, tx.size() - 1, 1'b0);
      check("t5_byte_cnt", n_byte, 3);
      check("t5_done_cnt", n_done, 0);
      en = 1'b1;
      clear_log(); send_all(1'b0);
      check("t5_aa_cnt", n_aa, 1);
      check("t5_crc_ok", done_ok, 1);

      // 6: reset mid-header with continuous strobes
      clear_log();
      send_range(0, 51, 1'b0);
      check("t6_pre_byte", bus.byte_out, 8'h40);
      rst = 1'b1;
      tick(1'b1, tx[52]);
      check("t6_rst_outs", {18'd0, aa_found, pkt_done, crc_ok, len_err, busy,
                            bus.byte_valid, bus.byte_out}, 32'd0);
      rst = 1'b0;
      clear_log();
      send_range(8, tx.size() - 1, 1'b0);
      for (int n = 0; n < 4; n++) tick(1'b0, 1'b0);
      check("t6_aa_cnt", n_aa, 1);
      check("t6_aa_idx", aa_idx, 31);
      check("t6_crc_ok", done_ok, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
